// File: rtl/cnt_shift_ring.sv
// -----------------------------------------------------------------------------
// cnt_shift_ring
//
// Shift-register sequencer that generalises the one-hot ring counter. It walks
// a WIDTH-bit register through either a one-hot ring (MODE=0, LEN=WIDTH steps)
// or a Johnson / twisted-ring sequence (MODE=1, LEN=2*WIDTH steps). Each step
// rotates in the direction requested that cycle. A binary step index and
// wrap/error pulses are kept alongside the register value.
//
// Parameters
//   WIDTH   register width (>= 2)
//   MODE    0 = one-hot ring, 1 = Johnson
//   LEN     derived sequence length
//   IDX_W   derived index width, $clog2(LEN)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, returns to the seed state
//   en        in   advance one step this cycle
//   dir       in   0 = rotate toward LSB (index +1), 1 = toward MSB (index -1)
//   load      in   parallel load request, wins over en
//   load_val  in   value to load; rejected unless it is a legal sequence state
//   o_cnt     out  current sequence state
//   o_idx     out  binary step index of o_cnt, 0..LEN-1
//   o_wrap    out  one-cycle pulse when the last step crossed LEN-1 <-> 0
//   o_err     out  one-cycle pulse on a rejected load or illegal-state repair
//
// All outputs are registered; o_idx is updated in the same edge as o_cnt so
// the two always describe the same step.
// -----------------------------------------------------------------------------
module cnt_shift_ring #(
    parameter  int WIDTH = 4,
    parameter  int MODE  = 0,
    localparam int LEN   = (MODE == 1) ? 2 * WIDTH : WIDTH,
    localparam int IDX_W = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_wrap,
    output logic             o_err
);

    // Index 0 of the sequence: a single LSB for the ring, all zeros for Johnson.
    localparam logic [WIDTH-1:0] SEED     = (MODE == 1) ? '0 : WIDTH'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             wrap_q;
    logic             err_q;

    logic             cnt_legal;
    logic             load_legal;
    logic [IDX_W-1:0] load_idx;
    logic [WIDTH-1:0] cnt_right;
    logic [WIDTH-1:0] cnt_left;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    function automatic int popcnt(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = n + 1;
        end
        return n;
    endfunction

    // Ring: exactly one bit set.
    // Johnson: a thermometer anchored at either end. With n ones the only two
    // candidates are n ones packed against the MSB or n ones packed against the
    // LSB; all-zero and all-one satisfy both forms.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] ones;
        int               n;
        ones = '1;
        n    = popcnt(v);
        if (MODE == 1) begin
            return (v == ~(ones >> n)) || (v == ~(ones << n));
        end
        return (n == 1);
    endfunction

    // Step index of a legal value.
    // Ring: the seed bit sits at position 0 and right rotation moves it down,
    // so position p is reached after (WIDTH - p) mod WIDTH right steps.
    // Johnson: the first half fills ones in from the MSB (index = popcount),
    // the second half drains them out from the MSB, leaving ones at the LSB
    // (index = 2*WIDTH - popcount). All-ones is the halfway point.
    function automatic logic [IDX_W-1:0] index_of(input logic [WIDTH-1:0] v);
        int n;
        int p;
        if (MODE == 1) begin
            n = popcnt(v);
            if (!v[0] || (n == WIDTH)) begin
                return IDX_W'(n);
            end
            return IDX_W'(2 * WIDTH - n);
        end
        p = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) p = i;
        end
        return IDX_W'((WIDTH - p) % WIDTH);
    endfunction

    // Johnson feeds back the inverted bit that falls off the end; the ring
    // feeds it back unchanged.
    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        logic fb;
        fb = (MODE == 1) ? ~v[0] : v[0];
        return {fb, v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        logic fb;
        fb = (MODE == 1) ? ~v[WIDTH-1] : v[WIDTH-1];
        return {v[WIDTH-2:0], fb};
    endfunction

    // -------------------------------------------------------------------------
    // Next-state candidates
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_legal  = is_legal(cnt_q);
        load_legal = is_legal(load_val);
        load_idx   = index_of(load_val);
        cnt_right  = rot_right(cnt_q);
        cnt_left   = rot_left(cnt_q);
        // LEN need not be a power of two, so wrap explicitly.
        idx_inc    = (idx_q == IDX_LAST) ? IDX_ZERO : idx_q + IDX_ONE;
        idx_dec    = (idx_q == IDX_ZERO) ? IDX_LAST : idx_q - IDX_ONE;
    end

    // -------------------------------------------------------------------------
    // State register: rst > load > en
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= SEED;
            idx_q  <= IDX_ZERO;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (load) begin
                // A rejected load keeps the current state untouched.
                if (load_legal) begin
                    cnt_q <= load_val;
                    idx_q <= load_idx;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (en) begin
                if (!cnt_legal) begin
                    // Upset repair: only attempted when a step is requested,
                    // so an idle sequencer never changes state on its own.
                    cnt_q <= SEED;
                    idx_q <= IDX_ZERO;
                    err_q <= 1'b1;
                end else if (!dir) begin
                    cnt_q  <= cnt_right;
                    idx_q  <= idx_inc;
                    wrap_q <= (idx_q == IDX_LAST);
                end else begin
                    cnt_q  <= cnt_left;
                    idx_q  <= idx_dec;
                    wrap_q <= (idx_q == IDX_ZERO);
                end
            end
        end
    end

    assign o_cnt  = cnt_q;
    assign o_idx  = idx_q;
    assign o_wrap = wrap_q;
    assign o_err  = err_q;

endmodule

// File: doc/cnt_shift_ring.md
# cnt_shift_ring

Parametrised shift-register sequencer that generalises the one-hot ring counter. It supports configurable width, a one-hot ring or Johnson (twisted-ring) sequence, and runtime rotation direction. It also provides enable, validated parallel load, illegal-state self-correction, a binary step index and a wrap pulse. It drives one-hot or thermometer phase selects in sequencing and timing-generation logic.

## Interface

Parameters:
- WIDTH, default 4: register width, must be >= 2.
- MODE, default 0: sequence type. 0 = one-hot ring; 1 = Johnson.
- LEN (derived, not overridable): sequence length. WIDTH when MODE=0; 2*WIDTH when MODE=1.
- IDX_W (derived): $clog2(LEN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  advance one step this cycle.
- dir  in  1  step direction. 0 = rotate toward LSB; 1 = rotate toward MSB.
- load  in  1  parallel load request.
- load_val  in  WIDTH  value to load.
- o_cnt  out  WIDTH  current sequence state.
- o_idx  out  IDX_W  binary step index of o_cnt, 0..LEN-1.
- o_wrap  out  1  one-cycle pulse when the last step crossed the LEN-1/0 boundary.
- o_err  out  1  one-cycle pulse on a rejected load or an illegal-state correction.

## Operation

- Seed state (index 0):
  - MODE=0: 0...01.
  - MODE=1: 0...00.
- Right step (dir=0):
  - MODE=0: {q[0], q[WIDTH-1:1]}.
  - MODE=1: {~q[0], q[WIDTH-1:1]}.
  - Index increments mod LEN.
- Left step (dir=1):
  - MODE=0: {q[WIDTH-2:0], q[WIDTH-1]}.
  - MODE=1: {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Index decrements mod LEN.
- Legal states:
  - MODE=0: exactly one bit set.
  - MODE=1: thermometer patterns only, either ones contiguous from the MSB (1..10..0, including all-0 and all-1) or ones contiguous from the LSB (0..01..1).
- Index mapping, derived from the value:
  - MODE=0: with p the position of the set bit, idx = (WIDTH - p) mod WIDTH.
  - MODE=1: with n = popcount, idx = n when q[0]=0 or q is all-ones; otherwise idx = 2*WIDTH - n.
- Priority: rst > load > en.
  - rst: o_cnt = seed, o_idx = 0, o_wrap = 0, o_err = 0.
  - load with legal load_val: o_cnt = load_val, o_idx = mapped index, o_wrap = 0, o_err = 0. en is ignored that cycle; no step occurs.
  - load with illegal load_val: state holds, o_wrap = 0, o_err = 1 for one cycle. en is ignored.
  - en with a legal current state: one step in direction dir. o_wrap = 1 if the step went right from LEN-1 to 0, or left from 0 to LEN-1.
  - en with an illegal current state (reachable only through upset or force): o_cnt = seed, o_idx = 0, o_err = 1.
  - No request: state holds, o_wrap = 0, o_err = 0.
- dir may change on any cycle; each step uses the dir value sampled in that cycle.

## Timing

- All outputs are registered. Each change appears one cycle after the triggering edge.
- o_idx is always consistent with o_cnt in the same cycle. There is no combinational path from inputs to outputs.
- o_wrap and o_err are single-cycle pulses. With en held high and a continuous stream of steps, o_wrap fires once every LEN cycles.
- Reset mid-sequence returns to seed on the next edge, regardless of load, en or dir.
- Illegal-state correction happens only on a cycle with en=1. With en=0, an illegal state holds.

## Test plan

- Ring right (WIDTH=4, MODE=0): pulse rst, then en=1, dir=0 for 4 cycles → o_cnt 1000/0100/0010/0001, o_idx 1/2/3/0. o_wrap is 1 only with the final 0001.
- Ring left: from seed, en=1, dir=1 → 0010 with idx 3 and o_wrap=1, then 0100 with idx 2. Toggling dir between 0 and 1 on alternate cycles → state alternates between 0001 and 0010.
- Load and hold (MODE=0): en=0 for 3 cycles → state holds. load_val=0100 → o_cnt 0100, idx 2, o_err 0. load_val=0110 → state unchanged, o_err=1 for one cycle. load=1 together with en=1 → loaded value, no step.
- Johnson (WIDTH=4, MODE=1): 8 right steps from seed → 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000 with idx 1..7, 0, and o_wrap with the final 0000. load_val=0011 → idx 6. load_val=1010 → rejected, o_err=1.
- Priority and reset: rst=1 with load=1 and en=1 → seed, all flags 0. rst asserted at idx 2 mid-sequence → seed on the next edge.
- Self-correction (MODE=0): force o_cnt state to 0000, then en=1 → 0001, idx 0, o_err=1 for one cycle. With en=0, the forced 0110 is held and o_err stays 0.
